// File: rtl/rifl_rx_flow_ctrl.sv
// rifl_rx_flow_ctrl: receive-side flow and go-back-N retransmission control
// for the RIFL lane, frame clock domain.
//   - Gates rx user buffer writes to in-sequence, CRC-good frames.
//   - Issues a retransmission request on the first rejected frame and
//     re-issues it every RETRANS_TIMEOUT cycles until the frame arrives.
//   - Drives pause_req from buffer occupancy with hysteresis.
// Optional feature macro: RIFL_RX_FLOW_CTRL_ERR_CNT_EN
//   defined   -> err_cnt counts rejected frames (saturating at 16'hFFFF)
//   undefined -> err_cnt tied to 16'h0

module rifl_rx_flow_ctrl #(
   parameter int unsigned FRAME_ID_WIDTH  = 8,
   parameter int unsigned BUFFER_DEPTH    = 1 << (FRAME_ID_WIDTH + 1),
   parameter int unsigned PAUSE_ON_VAL    = 2 * BUFFER_DEPTH / 3,
   parameter int unsigned PAUSE_OFF_VAL   = BUFFER_DEPTH / 3,
   parameter int unsigned RETRANS_TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_up,
   input  logic                          frame_vld,
   input  logic                          frame_crc_good,
   input  logic [FRAME_ID_WIDTH-1:0]     frame_id,
   output logic                          frame_accept,
   input  logic [$clog2(BUFFER_DEPTH):0] fifo_cnt,
   output logic                          pause_req,
   output logic                          retrans_req,
   output logic [FRAME_ID_WIDTH-1:0]     retrans_id,
   output logic [FRAME_ID_WIDTH-1:0]     expected_id,
   output logic [15:0]                   err_cnt
);

   localparam int unsigned CNT_W   = $clog2(BUFFER_DEPTH) + 1;
   localparam int unsigned TIMER_W = $clog2(RETRANS_TIMEOUT);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] RUN          = 2'd1;
   localparam logic [1:0] RETRANS_WAIT = 2'd2;

   localparam logic [TIMER_W-1:0]        TIMER_RELOAD = TIMER_W'(RETRANS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]          PAUSE_ON     = CNT_W'(PAUSE_ON_VAL);
   localparam logic [CNT_W-1:0]          PAUSE_OFF    = CNT_W'(PAUSE_OFF_VAL);
   localparam logic [FRAME_ID_WIDTH-1:0] ID_ONE       = FRAME_ID_WIDTH'(1);

   logic [1:0]                state;
   logic [1:0]                state_nxt;
   logic [TIMER_W-1:0]        timer;
   logic [TIMER_W-1:0]        timer_nxt;
   logic [FRAME_ID_WIDTH-1:0] expected_id_nxt;
   logic [FRAME_ID_WIDTH-1:0] retrans_id_nxt;
   logic                      retrans_req_nxt;
   logic                      pause_req_nxt;
   logic                      linked;
   logic                      in_seq;

   // Link is usable only once out of IDLE and while rx_up is still high
   assign linked = rx_up & (state != IDLE);

   // A frame is in-sequence when valid, CRC-good and carrying the expected ID
   assign in_seq = frame_vld & frame_crc_good & (frame_id == expected_id);

   // Buffer write enable: same cycle as frame_vld
   assign frame_accept = linked & in_seq;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         expected_id <= '0;
         retrans_id  <= '0;
         retrans_req <= 1'b0;
         pause_req   <= 1'b0;
      end else begin
         state       <= state_nxt;
         timer       <= timer_nxt;
         expected_id <= expected_id_nxt;
         retrans_id  <= retrans_id_nxt;
         retrans_req <= retrans_req_nxt;
         pause_req   <= pause_req_nxt;
      end
   end

   // Next-state, sequence tracking, retransmission timer and pause hysteresis
   always_comb begin
      state_nxt       = state;
      timer_nxt       = timer;
      expected_id_nxt = expected_id;
      retrans_id_nxt  = retrans_id;
      retrans_req_nxt = 1'b0;
      pause_req_nxt   = pause_req;

      if (!rx_up) begin
         // Link loss overrides everything, including a coincident frame
         state_nxt       = IDLE;
         timer_nxt       = '0;
         expected_id_nxt = '0;
         retrans_id_nxt  = '0;
         pause_req_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt       = RUN;
               timer_nxt       = '0;
               expected_id_nxt = '0;
               pause_req_nxt   = 1'b0;
            end

            RUN: begin
               if (in_seq) begin
                  expected_id_nxt = expected_id + ID_ONE;
               end else if (frame_vld) begin
                  // First rejected frame: request resend from the expected ID
                  state_nxt       = RETRANS_WAIT;
                  retrans_req_nxt = 1'b1;
                  retrans_id_nxt  = expected_id;
                  timer_nxt       = TIMER_RELOAD;
               end
            end

            RETRANS_WAIT: begin
               if (in_seq) begin
                  // Resent frame arrived; an expiring timer is ignored
                  state_nxt       = RUN;
                  expected_id_nxt = expected_id + ID_ONE;
                  timer_nxt       = '0;
               end else if (timer == '0) begin
                  retrans_req_nxt = 1'b1;
                  retrans_id_nxt  = expected_id;
                  timer_nxt       = TIMER_RELOAD;
               end else begin
                  timer_nxt = timer - TIMER_W'(1);
               end
            end

            default: begin
               state_nxt       = IDLE;
               timer_nxt       = '0;
               expected_id_nxt = '0;
               pause_req_nxt   = 1'b0;
            end
         endcase

         // Hysteresis: between the thresholds the previous request holds
         if (state != IDLE) begin
            if (fifo_cnt >= PAUSE_ON) begin
               pause_req_nxt = 1'b1;
            end else if (fifo_cnt <= PAUSE_OFF) begin
               pause_req_nxt = 1'b0;
            end
         end
      end
   end

`ifdef RIFL_RX_FLOW_CTRL_ERR_CNT_EN
   logic reject;

   // Any frame presented on a live link but not written is an error
   assign reject = linked & frame_vld & ~frame_accept;

   // Saturating rejected-frame counter, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 16'h0;
      end else if (reject && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`else
   assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_rifl_rx_flow_ctrl.sv
// Self-checking bench for rifl_rx_flow_ctrl: directed scenarios followed by
// randomized traffic, all compared against a deadline-based reference model.
`timescale 1ns/1ps

module tb_rifl_rx_flow_ctrl;

   localparam int unsigned W   = 8;
   localparam int unsigned T   = 16;
   localparam int unsigned ON  = 341;
   localparam int unsigned OFF = 170;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_up;
   logic        frame_vld;
   logic        frame_crc_good;
   logic [7:0]  frame_id;
   logic        frame_accept;
   logic [9:0]  fifo_cnt;
   logic        pause_req;
   logic        retrans_req;
   logic [7:0]  retrans_id;
   logic [7:0]  expected_id;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit       m_linked;
   bit       m_wait;
   bit       m_req;
   bit       m_pause;
   bit [7:0] m_exp;
   bit [7:0] m_rid;
   int       m_err;
   int       m_last_rise;
   int       cyc = 0;

   rifl_rx_flow_ctrl #(
      .FRAME_ID_WIDTH (W),
      .RETRANS_TIMEOUT(T)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_up         (rx_up),
      .frame_vld     (frame_vld),
      .frame_crc_good(frame_crc_good),
      .frame_id      (frame_id),
      .frame_accept  (frame_accept),
      .fifo_cnt      (fifo_cnt),
      .pause_req     (pause_req),
      .retrans_req   (retrans_req),
      .retrans_id    (retrans_id),
      .expected_id   (expected_id),
      .err_cnt       (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, want);
      end
   endtask

   function automatic logic [31:0] exp_err();
`ifdef RIFL_RX_FLOW_CTRL_ERR_CNT_EN
      return 32'(m_err);
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_clear();
      m_linked = 0; m_wait = 0; m_req = 0; m_pause = 0;
      m_exp = 0; m_rid = 0; m_err = 0; m_last_rise = 0;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately
   task automatic do_reset();
      #2;
      rst = 1'b1;
      rx_up = 1'b0; frame_vld = 1'b0; frame_crc_good = 1'b0; frame_id = '0;
      #1;
      model_clear();
      check("rst_retrans_req", 32'(retrans_req), 0);
      check("rst_retrans_id",  32'(retrans_id),  0);
      check("rst_expected_id", 32'(expected_id), 0);
      check("rst_pause_req",   32'(pause_req),   0);
      check("rst_err_cnt",     32'(err_cnt),     0);
      check("rst_accept",      32'(frame_accept), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive at negedge, check combinational accept, step model, check registers
   task automatic cycle(input bit up, input bit vld, input bit good,
                        input bit [7:0] id, input bit [9:0] cnt);
      bit acc;
      rx_up = up; frame_vld = vld; frame_crc_good = good; frame_id = id; fifo_cnt = cnt;
      #1;
      acc = up && m_linked && vld && good && (id == m_exp);
      check("frame_accept", 32'(frame_accept), 32'(acc));
      @(posedge clk);
      cyc++;
      m_req = 0;
      if (!up) begin
         m_linked = 0; m_wait = 0; m_exp = 0; m_pause = 0; m_rid = 0;
      end else if (!m_linked) begin
         m_linked = 1;
      end else begin
         if (vld && !acc && m_err < 65535) m_err++;
         if (acc) begin
            m_exp++;
            m_wait = 0;
         end else if (vld && !m_wait) begin
            m_wait = 1; m_req = 1; m_rid = m_exp; m_last_rise = cyc;
         end else if (m_wait && (cyc - m_last_rise == int'(T))) begin
            m_req = 1; m_last_rise = cyc;
         end
         if (cnt >= ON) m_pause = 1;
         else if (cnt <= OFF) m_pause = 0;
      end
      #1;
      check("retrans_req", 32'(retrans_req), 32'(m_req));
      if (m_req) check("retrans_id", 32'(retrans_id), 32'(m_rid));
      check("expected_id", 32'(expected_id), 32'(m_exp));
      check("pause_req",   32'(pause_req),   32'(m_pause));
      check("err_cnt",     32'(err_cnt),     exp_err());
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n, input bit [9:0] cnt);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, cnt);
   endtask

   task automatic good_frame(input bit [7:0] id);
      cycle(1, 1, 1, id, 0);
   endtask

   initial begin
      bit [9:0] cnt;
      bit       up;
      bit [7:0] id;
      int       pulses;

      rst = 1'b1;
      rx_up = 0; frame_vld = 0; frame_crc_good = 0; frame_id = 0; fifo_cnt = 0;
      @(negedge clk);
      do_reset();

      // In-order good frames 0..5
      idle_cycles(1, 0);
      for (int i = 0; i < 6; i++) good_frame(8'(i));
      check("seq_expected_id", 32'(expected_id), 6);

      // Bad CRC on 2, discard 3 and 4, then resend of 2
      do_reset();
      idle_cycles(1, 0);
      good_frame(0);
      good_frame(1);
      cycle(1, 1, 0, 2, 0);
      good_frame(3);
      good_frame(4);
      good_frame(2);
      check("gbn_expected_id", 32'(expected_id), 3);

      // Repeated requests on timeout, reject at ID 7
      do_reset();
      idle_cycles(1, 0);
      for (int i = 0; i < 7; i++) good_frame(8'(i));
      cycle(1, 1, 0, 7, 0);
      pulses = 1;
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0, 0, 0, 0);
         if (retrans_req) pulses++;
      end
      check("timeout_pulses", 32'(pulses), 3);

      // Pause hysteresis ramp 0 -> 400 -> 100
      do_reset();
      idle_cycles(1, 0);
      for (int c = 0; c <= 400; c++) cycle(1, 0, 0, 0, 10'(c));
      for (int c = 399; c >= 100; c--) cycle(1, 0, 0, 0, 10'(c));

      // ID wrap 255 -> 0
      do_reset();
      idle_cycles(1, 0);
      for (int i = 0; i < 256; i++) good_frame(8'(i));
      good_frame(0);
      check("wrap_expected_id", 32'(expected_id), 1);

      // Link drop in RETRANS_WAIT with a coincident frame
      do_reset();
      idle_cycles(1, 0);
      good_frame(0);
      cycle(1, 1, 1, 5, 0);
      cycle(0, 1, 1, 1, 0);
      cycle(1, 0, 0, 0, 0);
      good_frame(0);

      // Async reset in the middle of a retransmission wait
      cycle(1, 1, 0, 1, 0);
      idle_cycles(3, 0);
      do_reset();
      idle_cycles(2, 0);

      // Randomized traffic
      cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         if ((i % 1500) == 1499) do_reset();
         up = ($urandom_range(99) != 0);
         id = ($urandom_range(3) != 0) ? m_exp : 8'($urandom);
         if ($urandom_range(1) != 0)
            cnt = (cnt > 10'd490) ? 10'd512 : cnt + 10'($urandom_range(22));
         else
            cnt = (cnt < 10'd22) ? 10'd0 : cnt - 10'($urandom_range(22));
         cycle(up, $urandom_range(1) != 0, $urandom_range(7) != 0, id, cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
